window3x3_gen: RTL and testbench

//   Builds a 3x3 sliding pixel window from a raster-scan pixel stream and two

---
 rtl/window3x3_gen.sv | 123 ++++++++++++
 tb/tb_window3x3_gen.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/window3x3_gen.sv
// 3x3 sliding-window builder over a raster pixel stream plus two line-delayed copies.
// Emits only interior windows and flags stream gaps or premature start-of-frame.
module window3x3_gen #(
  parameter int DATA_W = 16,
  parameter int IMG_W  = 257,
  parameter int IMG_H  = 257,
  parameter int CW     = 9
) (
  input  logic                ap_clk,
  input  logic                reset_n,
  input  logic                sof,
  input  logic                in_valid,
  input  logic [DATA_W-1:0]   pix_in,
  input  logic [DATA_W-1:0]   line1_in,
  input  logic [DATA_W-1:0]   line2_in,
  output logic                out_valid,
  output logic [9*DATA_W-1:0] window,
  output logic [CW-1:0]       out_row,
  output logic [CW-1:0]       out_col,
  output logic                frame_done,
  output logic                err
);

  // Input handshake: there is no back-pressure. A pixel is taken on every clock
  // where in_valid is high in ACTIVE, or where in_valid and sof are both high in
  // IDLE/ERR. out_valid is a one-cycle qualifier with no ready.
  typedef enum logic [1:0] {IDLE, ACTIVE, ERR} state_t;

  localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);
  localparam logic [CW-1:0] LAST_ROW = CW'(IMG_H - 1);
  localparam logic [CW-1:0] TWO      = CW'(2);
  localparam logic [CW-1:0] ONE      = CW'(1);

  state_t              state;
  logic [CW-1:0]       row_q, col_q;
  logic [DATA_W-1:0]   taps [3][3];
  logic [DATA_W-1:0]   taps_next [3][3];
  logic                last_q;

  logic                accept, emit, col_wrap, is_last;
  logic [CW-1:0]       pos_row, pos_col, nxt_row, nxt_col;
  logic [9*DATA_W-1:0] win_next;

  always_comb begin
    accept   = in_valid && ((state == ACTIVE) || sof);
    // sof always re-bases the accepted pixel to (0,0), including a mid-frame restart
    pos_row  = sof ? '0 : row_q;
    pos_col  = sof ? '0 : col_q;
    col_wrap = (pos_col == LAST_COL);
    is_last  = col_wrap && (pos_row == LAST_ROW);
    nxt_col  = col_wrap ? '0 : pos_col + ONE;
    nxt_row  = col_wrap ? (is_last ? '0 : pos_row + ONE) : pos_row;
    emit     = accept && (pos_row >= TWO) && (pos_col >= TWO);
  end

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      taps_next[i][0] = taps[i][1];
      taps_next[i][1] = taps[i][2];
      taps_next[i][2] = '0;
    end
    taps_next[0][2] = line2_in;
    taps_next[1][2] = line1_in;
    taps_next[2][2] = pix_in;
    win_next = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        win_next[DATA_W*(3*i+j) +: DATA_W] = taps_next[i][j];
      end
    end
  end

  always_ff @(posedge ap_clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      row_q      <= '0;
      col_q      <= '0;
      last_q     <= 1'b0;
      out_valid  <= 1'b0;
      window     <= '0;
      out_row    <= '0;
      out_col    <= '0;
      frame_done <= 1'b0;
      err        <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          taps[i][j] <= '0;
        end
      end
    end else begin
      out_valid  <= emit;
      last_q     <= accept && is_last;
      frame_done <= last_q;
      if (accept) begin
        taps  <= taps_next;
        row_q <= nxt_row;
        col_q <= nxt_col;
      end
      // Output registers load only for interior windows so they hold otherwise
      if (emit) begin
        window  <= win_next;
        out_row <= pos_row - ONE;
        out_col <= pos_col - ONE;
      end
      case (state)
        IDLE, ERR: begin
          if (in_valid && sof) state <= ACTIVE;
        end
        ACTIVE: begin
          if (!in_valid) begin
            state <= ERR;
            err   <= 1'b1;
          end else begin
            if (sof && ((row_q != '0) || (col_q != '0))) err <= 1'b1;
            if (is_last) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_window3x3_gen.sv
// Self-checking bench for window3x3_gen on a 5x5 image; line inputs come from a
// per-clock delay model of the driven pixel stream, windows from an image model.
module tb_window3x3_gen;
  localparam int DATA_W = 16;
  localparam int IMG_W  = 5;
  localparam int IMG_H  = 5;
  localparam int CW     = 9;
  localparam int EW     = 2*CW + 9*DATA_W;

  logic                ap_clk = 1'b0;
  logic                reset_n = 1'b0;
  logic                sof = 1'b0;
  logic                in_valid = 1'b0;
  logic [DATA_W-1:0]   pix_in = '0;
  logic [DATA_W-1:0]   line1_in = '0;
  logic [DATA_W-1:0]   line2_in = '0;
  logic                out_valid;
  logic [9*DATA_W-1:0] window;
  logic [CW-1:0]       out_row;
  logic [CW-1:0]       out_col;
  logic                frame_done;
  logic                err;

  window3x3_gen #(.DATA_W(DATA_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .CW(CW)) dut (
    .ap_clk(ap_clk), .reset_n(reset_n), .sof(sof), .in_valid(in_valid),
    .pix_in(pix_in), .line1_in(line1_in), .line2_in(line2_in),
    .out_valid(out_valid), .window(window), .out_row(out_row), .out_col(out_col),
    .frame_done(frame_done), .err(err)
  );

  // ---------------- clock / reset block ----------------
  always #5 ap_clk = ~ap_clk;

  int cyc = 0;
  always @(posedge ap_clk) cyc <= cyc + 1;

  // ---------------- monitor (only appends) ----------------
  logic [EW-1:0] got_q[$];
  int            rec_q[$];
  int            done_q[$];
  int            err_cnt = 0;

  always @(negedge ap_clk) begin
    if (out_valid) begin
      got_q.push_back({out_row, out_col, window});
      rec_q.push_back(cyc);
    end
    if (frame_done) done_q.push_back(cyc);
    if (err) err_cnt = err_cnt + 1;
  end

  // ---------------- scoreboard / reference model ----------------
  logic [EW-1:0]     exp_q[$];
  logic [DATA_W-1:0] hist[$];
  logic [DATA_W-1:0] img [IMG_H][IMG_W];
  int                acc_cyc [IMG_H*IMG_W];
  int                checks = 0;
  int                failures = 0;

  task automatic make_img(input bit ramp);
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++)
        img[r][c] = ramp ? DATA_W'(10*r + c) : DATA_W'($urandom_range(0, 65535));
  endtask

  // Expected windows for the accepted pixels lo..hi of the current image
  task automatic expect_pixels(input int lo, input int hi);
    logic [9*DATA_W-1:0] w;
    for (int idx = lo; idx <= hi; idx++) begin
      int r, c;
      r = idx / IMG_W;
      c = idx % IMG_W;
      if (r >= 2 && c >= 2) begin
        w = '0;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            w[DATA_W*(3*i+j) +: DATA_W] = img[r-2+i][c-2+j];
        exp_q.push_back({CW'(r-1), CW'(c-1), w});
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic s, input logic [DATA_W-1:0] p);
    int n;
    n = hist.size();
    in_valid = v;
    sof      = s;
    pix_in   = p;
    line1_in = (n >= IMG_W)   ? hist[n-IMG_W]   : '0;
    line2_in = (n >= 2*IMG_W) ? hist[n-2*IMG_W] : '0;
    @(posedge ap_clk);
    hist.push_back(p);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, DATA_W'($urandom));
  endtask

  task automatic send_pix(input int lo, input int hi);
    for (int idx = lo; idx <= hi; idx++) begin
      drive(1'b1, idx == 0, img[idx / IMG_W][idx % IMG_W]);
      acc_cyc[idx] = cyc;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    idle(3);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    checks++; if (window !== '0) begin failures++; $display("FAIL reset_window got=%h exp=0", window); end
    checks++; if (out_row !== '0 || out_col !== '0) begin failures++; $display("FAIL reset_rowcol got=%0d,%0d exp=0,0", out_row, out_col); end
    checks++; if (frame_done !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL reset_done_err got=%0b,%0b exp=0,0", frame_done, err); end
    reset_n = 1'b1;
    idle(2);
  endtask

  task automatic test_ramp_frame();
    int gb, db, eb;
    gb = got_q.size(); db = done_q.size(); eb = err_cnt;
    exp_q.delete();
    make_img(1'b1);
    expect_pixels(0, IMG_W*IMG_H-1);
    send_pix(0, IMG_W*IMG_H-1);
    idle(4);
    checks++; if (got_q.size() - gb != 9) begin failures++; $display("FAIL ramp_count got=%0d exp=9", got_q.size() - gb); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (got_q.size() <= gb + i) begin failures++; $display("FAIL ramp_win%0d got=none exp=%h", i, exp_q[i]); end
      else if (got_q[gb+i] !== exp_q[i]) begin failures++; $display("FAIL ramp_win%0d got=%h exp=%h", i, got_q[gb+i], exp_q[i]); end
    end
    if (rec_q.size() > gb) begin
      checks++; if (rec_q[gb] !== acc_cyc[12]) begin failures++; $display("FAIL ramp_first_latency got=%0d exp=%0d", rec_q[gb], acc_cyc[12]); end
    end
    checks++;
    if (done_q.size() - db != 1) begin failures++; $display("FAIL ramp_done_count got=%0d exp=1", done_q.size() - db); end
    else if (done_q[db] !== acc_cyc[24] + 1) begin failures++; $display("FAIL ramp_done_time got=%0d exp=%0d", done_q[db], acc_cyc[24] + 1); end
    checks++; if (err_cnt != eb) begin failures++; $display("FAIL ramp_err got=%0d_cycles exp=0", err_cnt - eb); end
  endtask

  task automatic test_gap();
    int gb, db;
    gb = got_q.size(); db = done_q.size();
    exp_q.delete();
    make_img(1'b0);
    expect_pixels(0, 12);
    send_pix(0, 12);
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL gap_err_before got=%0b exp=0", err); end
    drive(1'b0, 1'b0, DATA_W'($urandom));
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL gap_err_after got=%0b exp=1", err); end
    for (int idx = 13; idx < IMG_W*IMG_H; idx++) drive(1'b1, 1'b0, img[idx / IMG_W][idx % IMG_W]);
    make_img(1'b0);
    expect_pixels(0, IMG_W*IMG_H-1);
    send_pix(0, IMG_W*IMG_H-1);
    idle(3);
    checks++; if (got_q.size() - gb != 10) begin failures++; $display("FAIL gap_count got=%0d exp=10", got_q.size() - gb); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (got_q.size() <= gb + i) begin failures++; $display("FAIL gap_win%0d got=none exp=%h", i, exp_q[i]); end
      else if (got_q[gb+i] !== exp_q[i]) begin failures++; $display("FAIL gap_win%0d got=%h exp=%h", i, got_q[gb+i], exp_q[i]); end
    end
    checks++; if (done_q.size() - db != 1) begin failures++; $display("FAIL gap_done_count got=%0d exp=1", done_q.size() - db); end
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL gap_err_sticky got=%0b exp=1", err); end
  endtask

  task automatic test_back_to_back();
    int gb, db;
    gb = got_q.size(); db = done_q.size();
    exp_q.delete();
    make_img(1'b0);
    expect_pixels(0, IMG_W*IMG_H-1);
    send_pix(0, IMG_W*IMG_H-1);
    make_img(1'b0);
    expect_pixels(0, IMG_W*IMG_H-1);
    send_pix(0, IMG_W*IMG_H-1);
    idle(3);
    checks++; if (got_q.size() - gb != 18) begin failures++; $display("FAIL b2b_count got=%0d exp=18", got_q.size() - gb); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (got_q.size() <= gb + i) begin failures++; $display("FAIL b2b_win%0d got=none exp=%h", i, exp_q[i]); end
      else if (got_q[gb+i] !== exp_q[i]) begin failures++; $display("FAIL b2b_win%0d got=%h exp=%h", i, got_q[gb+i], exp_q[i]); end
    end
    checks++;
    if (done_q.size() - db != 2) begin failures++; $display("FAIL b2b_done_count got=%0d exp=2", done_q.size() - db); end
    else if (done_q[db+1] - done_q[db] != IMG_W*IMG_H) begin failures++; $display("FAIL b2b_done_spacing got=%0d exp=%0d", done_q[db+1] - done_q[db], IMG_W*IMG_H); end
  endtask

  task automatic test_mid_reset();
    int gb, db;
    gb = got_q.size(); db = done_q.size();
    exp_q.delete();
    make_img(1'b0);
    expect_pixels(0, 15);
    send_pix(0, 15);
    reset_n = 1'b0;
    drive(1'b1, 1'b0, img[3][1]);
    reset_n = 1'b1;
    checks++; if (out_valid !== 1'b0 || frame_done !== 1'b0) begin failures++; $display("FAIL mrst_valid_done got=%0b,%0b exp=0,0", out_valid, frame_done); end
    checks++; if (window !== '0 || out_row !== '0 || out_col !== '0) begin failures++; $display("FAIL mrst_outputs got=%h,%0d,%0d exp=0,0,0", window, out_row, out_col); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL mrst_err got=%0b exp=0", err); end
    repeat (6) drive(1'b1, 1'b0, DATA_W'($urandom));
    checks++; if (got_q.size() - gb != 3) begin failures++; $display("FAIL mrst_nosof got=%0d exp=3", got_q.size() - gb); end
    make_img(1'b0);
    expect_pixels(0, IMG_W*IMG_H-1);
    send_pix(0, IMG_W*IMG_H-1);
    idle(3);
    checks++; if (got_q.size() - gb != 12) begin failures++; $display("FAIL mrst_count got=%0d exp=12", got_q.size() - gb); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (got_q.size() <= gb + i) begin failures++; $display("FAIL mrst_win%0d got=none exp=%h", i, exp_q[i]); end
      else if (got_q[gb+i] !== exp_q[i]) begin failures++; $display("FAIL mrst_win%0d got=%h exp=%h", i, got_q[gb+i], exp_q[i]); end
    end
    checks++; if (done_q.size() - db != 1) begin failures++; $display("FAIL mrst_done_count got=%0d exp=1", done_q.size() - db); end
  endtask

  task automatic test_restart();
    int gb, db;
    gb = got_q.size(); db = done_q.size();
    exp_q.delete();
    make_img(1'b0);
    send_pix(0, 8);
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL rst_err_before got=%0b exp=0", err); end
    make_img(1'b0);
    expect_pixels(0, IMG_W*IMG_H-1);
    send_pix(0, 0);
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL rst_err_after got=%0b exp=1", err); end
    send_pix(1, IMG_W*IMG_H-1);
    idle(3);
    checks++; if (got_q.size() - gb != 9) begin failures++; $display("FAIL rst_count got=%0d exp=9", got_q.size() - gb); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (got_q.size() <= gb + i) begin failures++; $display("FAIL rst_win%0d got=none exp=%h", i, exp_q[i]); end
      else if (got_q[gb+i] !== exp_q[i]) begin failures++; $display("FAIL rst_win%0d got=%h exp=%h", i, got_q[gb+i], exp_q[i]); end
    end
    checks++;
    if (done_q.size() - db != 1) begin failures++; $display("FAIL rst_done_count got=%0d exp=1", done_q.size() - db); end
    else if (done_q[db] !== acc_cyc[24] + 1) begin failures++; $display("FAIL rst_done_time got=%0d exp=%0d", done_q[db], acc_cyc[24] + 1); end
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    test_reset();
    test_ramp_frame();
    test_gap();
    test_back_to_back();
    test_mid_reset();
    test_restart();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
